// File: rtl/cmp_seq_ctrl.sv
// Multi-cycle unsigned compare of two SLICE*CHUNKS-bit operands using one SLICE-bit slice.
// Walks chunks MSB first and exits on the first unequal chunk, or after the LSB chunk.
module cmp_seq_ctrl #(
  parameter int SLICE  = 6,
  parameter int CHUNKS = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [SLICE*CHUNKS-1:0]      a,
  input  logic [SLICE*CHUNKS-1:0]      b,
  output logic                         ready,
  output logic                         done,
  output logic                         ageb,
  output logic                         agtb,
  output logic                         aeqb,
  output logic [$clog2(CHUNKS+1)-1:0]  nchunks
);

  localparam int W  = SLICE * CHUNKS;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int NW = $clog2(CHUNKS + 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      ra, rb;
  logic [IW-1:0]     idx;
  logic [NW-1:0]     cnt;
  logic [SLICE-1:0]  ca, cb;
  logic              chunk_gt, chunk_eq, last_chunk;

  function automatic logic [SLICE-1:0] chunk_of(input logic [W-1:0] v, input logic [IW-1:0] i);
    chunk_of = v[i*SLICE +: SLICE];
  endfunction

  assign ca         = chunk_of(ra, idx);
  assign cb         = chunk_of(rb, idx);
  assign chunk_gt   = (ca > cb);
  assign chunk_eq   = (ca == cb);
  assign last_chunk = (idx == '0);

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = CMP;
      end
      CMP: begin
        if (!chunk_eq || last_chunk) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, chunk walk and result registers; results move only on CMP exit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ra      <= '0;
      rb      <= '0;
      idx     <= '0;
      cnt     <= '0;
      agtb    <= 1'b0;
      aeqb    <= 1'b0;
      ageb    <= 1'b0;
      nchunks <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            idx <= IW'(CHUNKS - 1);
            cnt <= '0;
          end
        end
        CMP: begin
          if (!chunk_eq) begin
            agtb    <= chunk_gt;
            aeqb    <= 1'b0;
            ageb    <= chunk_gt;
            nchunks <= cnt + NW'(1);
          end else if (last_chunk) begin
            agtb    <= 1'b0;
            aeqb    <= 1'b1;
            ageb    <= 1'b1;
            nchunks <= NW'(CHUNKS);
          end else begin
            idx <= idx - IW'(1);
            cnt <= cnt + NW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Directed and randomized checks of cmp_seq_ctrl against a scoreboard of reference results.
module tb_cmp_seq_ctrl;

  localparam int SLICE  = 6;
  localparam int CHUNKS = 4;
  localparam int W      = SLICE * CHUNKS;
  localparam int NW     = $clog2(CHUNKS + 1);

  typedef struct {
    logic gt;
    logic eq;
    logic ge;
    int   k;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [W-1:0]  a, b;
  logic          ready, done, ageb, agtb, aeqb;
  logic [NW-1:0] nchunks;

  int   total;
  int   bad;
  exp_t sb[$];

  cmp_seq_ctrl #(.SLICE(SLICE), .CHUNKS(CHUNKS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .ageb    (ageb),
    .agtb    (agtb),
    .aeqb    (aeqb),
    .nchunks (nchunks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.gt = (x > y);
    e.eq = (x == y);
    e.ge = (x >= y);
    e.k  = 0;
    for (int i = CHUNKS - 1; i >= 0; i--) begin
      e.k++;
      if (x[i*SLICE +: SLICE] != y[i*SLICE +: SLICE]) break;
    end
    return e;
  endfunction

  // One transaction: push the reference, accept, then watch for done with a bounded wait.
  task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit hammer,
                     input bit verbose);
    exp_t e;
    exp_t r;
    bit   got;
    int   cyc;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (ready !== 1'b1) chk("ready_wait", {31'b0, ready}, 32'd1);
    sb.push_back(model(ta, tb_v));
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    @(posedge clk);
    #1;
    a     = ~ta;
    b     = ta ^ tb_v;
    start = hammer;
    got   = 1'b0;
    for (int c = 1; c <= CHUNKS + 3 && !got; c++) begin
      @(negedge clk);
      if (ready && done) chk("ready_and_done", {30'b0, ready, done}, 32'd0);
      if (hammer) chk("busy_ready", {31'b0, ready}, 32'd0);
      if (done === 1'b1) begin
        got   = 1'b1;
        start = 1'b0;
        r     = sb.pop_front();
        chk("latency", c, r.k + 1);
        if (verbose) begin
          chk("agtb", {31'b0, agtb}, {31'b0, r.gt});
          chk("aeqb", {31'b0, aeqb}, {31'b0, r.eq});
          chk("ageb", {31'b0, ageb}, {31'b0, r.ge});
          chk("nchunks", {{(32-NW){1'b0}}, nchunks}, r.k);
        end else begin
          chk("result", {28'b0, agtb, aeqb, ageb, 1'b0},
              {28'b0, r.gt, r.eq, r.ge, 1'b0});
          chk("nchunks", {{(32-NW){1'b0}}, nchunks}, r.k);
        end
      end
    end
    start = 1'b0;
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      e = r;
      @(negedge clk);
      chk("ready_after_done", {30'b0, ready, done}, 32'd2);
      if (verbose) chk("result_held", {31'b0, agtb}, {31'b0, e.gt});
    end
  endtask

  initial begin
    logic [W-1:0] ra_v, rb_v;
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_flags", {28'b0, done, ageb, agtb, aeqb}, 32'd0);
    chk("rst_nchunks", {{(32-NW){1'b0}}, nchunks}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases
    txn(24'hA5A5A5, 24'hA5A5A5, 1'b0, 1'b1);
    txn(24'hFC0000, 24'h000000, 1'b0, 1'b1);
    txn(24'hFFFFFE, 24'hFFFFFF, 1'b0, 1'b1);
    txn(24'h123456, 24'h123056, 1'b1, 1'b1);

    // Abort mid-compare with reset, then re-issue
    @(negedge clk);
    start = 1'b1;
    a     = 24'h000001;
    b     = 24'h000000;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, ready}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_flags", {28'b0, done, ageb, agtb, aeqb}, 32'd0);
    chk("abort_nchunks", {{(32-NW){1'b0}}, nchunks}, 32'd0);
    chk("abort_ready", {31'b0, ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'b0, done}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    txn(24'h000001, 24'h000000, 1'b0, 1'b1);

    // Random pairs, biased toward equal leading chunks
    for (int n = 0; n < 1000; n++) begin
      ra_v = W'($urandom);
      rb_v = ra_v;
      for (int c = 0; c < CHUNKS; c++)
        if ($urandom_range(0, 2) == 0) rb_v[c*SLICE +: SLICE] = SLICE'($urandom);
      txn(ra_v, rb_v, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
